// File: rtl/opll_bus_pkg.sv
// rtl/opll_bus_pkg.sv - shared types and default timing for the OPLL bus writer
//
// Contents:
//   bus_state_e   : writer FSM states, in bus-cycle order
//   opll_req_t    : one register-write request {addr, data}
//   DEF_*         : default strobe/wait timing in phiM clock cycles

package opll_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_STROBE,
        ST_ADDR_WAIT,
        ST_DATA_SETUP,
        ST_DATA_STROBE,
        ST_DATA_WAIT
    } bus_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } opll_req_t;

    localparam int DEF_ADDR_WAIT  = 12;
    localparam int DEF_DATA_WAIT  = 84;
    localparam int DEF_STROBE_LEN = 2;

endpackage

// File: rtl/opll_bus_writer_if.sv
// rtl/opll_bus_writer_if.sv - request handshake and OPLL chip bus bundle
//
// Signals:
//   i_req_valid / o_req_ready        : request handshake (accept on valid & ready)
//   i_reg_addr / i_reg_data          : register address and data of the request
//   o_D, o_A0, o_CS_n, o_WR_n        : OPLL chip bus pins
//   o_busy                           : writer busy or request buffered
// Modports:
//   master : request source / bus observer
//   slave  : the bus writer

interface opll_bus_writer_if;

    logic       i_req_valid;
    logic       o_req_ready;
    logic [7:0] i_reg_addr;
    logic [7:0] i_reg_data;
    logic [7:0] o_D;
    logic       o_A0;
    logic       o_CS_n;
    logic       o_WR_n;
    logic       o_busy;

    modport master (
        output i_req_valid, i_reg_addr, i_reg_data,
        input  o_req_ready, o_D, o_A0, o_CS_n, o_WR_n, o_busy
    );

    modport slave (
        input  i_req_valid, i_reg_addr, i_reg_data,
        output o_req_ready, o_D, o_A0, o_CS_n, o_WR_n, o_busy
    );

endinterface

// File: rtl/opll_bus_fifo.sv
// rtl/opll_bus_fifo.sv - small request FIFO in front of the OPLL bus writer
//
// Parameters: DEPTH - number of buffered requests
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push_i, wdata_i     : write side (ignored while full)
//   pop_i, rdata_o      : read side, rdata_o shows the head entry (ignored while empty)
//   full_o, empty_o     : occupancy flags

module opll_bus_fifo
    import opll_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  opll_req_t wdata_i,
    input  logic      pop_i,
    output opll_req_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);

    opll_req_t       mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == DEPTH_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/opll_bus_writer.sv
// rtl/opll_bus_writer.sv - sequences OPLL register writes onto the chip bus
//
// Turns each {addr, data} request into an address phase and a data phase,
// each being SETUP (1 cycle) -> STROBE (STROBE_LEN cycles, CS_n/WR_n low)
// -> WAIT (ADDR_WAIT / DATA_WAIT cycles).
// Build option: OPLL_BUS_WRITER_FIFO_EN adds a 4-entry request FIFO.
//
// Parameters: ADDR_WAIT, DATA_WAIT, STROBE_LEN (clk cycles)
// Ports:
//   clk    : OPLL phiM master clock
//   rst_n  : asynchronous active-low reset
//   bus    : opll_bus_writer_if.slave (request handshake + chip bus pins)

module opll_bus_writer
    import opll_bus_pkg::*;
#(
    parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter int DATA_WAIT  = DEF_DATA_WAIT,
    parameter int STROBE_LEN = DEF_STROBE_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    opll_bus_writer_if.slave    bus
);

    localparam logic [7:0] STROBE_CNT = 8'(STROBE_LEN);
    localparam logic [7:0] AWAIT_CNT  = 8'(ADDR_WAIT);
    localparam logic [7:0] DWAIT_CNT  = 8'(DATA_WAIT);

    bus_state_e  state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  d_q;
    logic        a0_q;
    logic        cs_n_q;
    logic        wr_n_q;
    logic [7:0]  data_q;

    logic        last_cycle;
    logic        slot_free;
    logic        start;
    opll_req_t   start_req;
    logic        buf_nonempty;

    // The final DATA_WAIT cycle counts as free so a waiting request goes
    // straight into ADDR_SETUP without an idle cycle in between.
    assign last_cycle = (state_q == ST_DATA_WAIT) && (cnt_q == 8'd1);
    assign slot_free  = (state_q == ST_IDLE) || last_cycle;

`ifdef OPLL_BUS_WRITER_FIFO_EN
    opll_req_t fifo_wdata;
    opll_req_t fifo_rdata;
    logic      fifo_full;
    logic      fifo_empty;

    assign fifo_wdata = '{addr: bus.i_reg_addr, data: bus.i_reg_data};

    opll_bus_fifo #(
        .DEPTH   (4)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.i_req_valid && !fifo_full),
        .wdata_i (fifo_wdata),
        .pop_i   (start),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.o_req_ready = !fifo_full;
    assign start           = slot_free && !fifo_empty;
    assign start_req       = fifo_rdata;
    assign buf_nonempty    = !fifo_empty;
`else
    assign bus.o_req_ready = slot_free;
    assign start           = slot_free && bus.i_req_valid;
    assign start_req       = '{addr: bus.i_reg_addr, data: bus.i_reg_data};
    assign buf_nonempty    = 1'b0;
`endif

    assign bus.o_D    = d_q;
    assign bus.o_A0   = a0_q;
    assign bus.o_CS_n = cs_n_q;
    assign bus.o_WR_n = wr_n_q;
    assign bus.o_busy = (state_q != ST_IDLE) || buf_nonempty;

    // D/A0 are loaded only on entry to a SETUP state, so they cannot move
    // while a strobe is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            d_q     <= 8'h00;
            a0_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ADDR_SETUP;
                        d_q     <= start_req.addr;
                        a0_q    <= 1'b0;
                        data_q  <= start_req.data;
                    end
                end
                ST_ADDR_SETUP: begin
                    state_q <= ST_ADDR_STROBE;
                    cnt_q   <= STROBE_CNT;
                    cs_n_q  <= 1'b0;
                    wr_n_q  <= 1'b0;
                end
                ST_ADDR_STROBE: begin
                    if (cnt_q == 8'd1) begin
                        state_q <= ST_ADDR_WAIT;
                        cnt_q   <= AWAIT_CNT;
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - 8'd1;
                    end
                end
                ST_ADDR_WAIT: begin
                    if (cnt_q == 8'd1) begin
                        state_q <= ST_DATA_SETUP;
                        cnt_q   <= 8'd0;
                        d_q     <= data_q;
                        a0_q    <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - 8'd1;
                    end
                end
                ST_DATA_SETUP: begin
                    state_q <= ST_DATA_STROBE;
                    cnt_q   <= STROBE_CNT;
                    cs_n_q  <= 1'b0;
                    wr_n_q  <= 1'b0;
                end
                ST_DATA_STROBE: begin
                    if (cnt_q == 8'd1) begin
                        state_q <= ST_DATA_WAIT;
                        cnt_q   <= DWAIT_CNT;
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - 8'd1;
                    end
                end
                ST_DATA_WAIT: begin
                    if (cnt_q == 8'd1) begin
                        cnt_q <= 8'd0;
                        if (start) begin
                            state_q <= ST_ADDR_SETUP;
                            d_q     <= start_req.addr;
                            a0_q    <= 1'b0;
                            data_q  <= start_req.data;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 8'd0;
                    cs_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opll_bus_writer.sv
// tb/tb_opll_bus_writer.sv - directed self-checking bench for opll_bus_writer

module tb_opll_bus_writer;
    import opll_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opll_bus_writer_if bus_a ();
    opll_bus_writer_if bus_f ();

    opll_bus_writer #(
        .ADDR_WAIT  (12),
        .DATA_WAIT  (84),
        .STROBE_LEN (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    opll_bus_writer #(
        .ADDR_WAIT  (1),
        .DATA_WAIT  (1),
        .STROBE_LEN (1)
    ) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // D/A0 must hold across consecutive low WR_n samples on both instances.
    logic [7:0] pd_a, pd_f;
    logic       pa0_a, pa0_f;
    logic       pwr_a = 1'b1;
    logic       pwr_f = 1'b1;

    always @(negedge clk) begin
        if (rst_n && !pwr_a && !bus_a.o_WR_n) begin
            chk("stable_d_a", {24'd0, bus_a.o_D}, {24'd0, pd_a});
            chk("stable_a0_a", {31'd0, bus_a.o_A0}, {31'd0, pa0_a});
        end
        if (rst_n && !pwr_f && !bus_f.o_WR_n) begin
            chk("stable_d_f", {24'd0, bus_f.o_D}, {24'd0, pd_f});
            chk("stable_a0_f", {31'd0, bus_f.o_A0}, {31'd0, pa0_f});
        end
        pd_a  <= bus_a.o_D;
        pa0_a <= bus_a.o_A0;
        pwr_a <= bus_a.o_WR_n;
        pd_f  <= bus_f.o_D;
        pa0_f <= bus_f.o_A0;
        pwr_f <= bus_f.o_WR_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Present one request on bus_a; returns at the negedge of cycle 1
    // (first cycle after the accepting edge) with valid dropped.
    task automatic send_a(input logic [7:0] a, input logic [7:0] d);
        int n;
        @(negedge clk);
        bus_a.i_req_valid = 1'b1;
        bus_a.i_reg_addr  = a;
        bus_a.i_reg_data  = d;
        n = 0;
        while (!bus_a.o_req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
    endtask

    logic [7:0] d_h    [0:110];
    logic       a0_h   [0:110];
    logic       wr_h   [0:110];
    logic       cs_h   [0:110];
    logic       busy_h [0:110];

    initial begin
        int lows;
        int diffs;
        int lowcnt;
        bus_a.i_req_valid = 1'b0;
        bus_a.i_reg_addr  = 8'h00;
        bus_a.i_reg_data  = 8'h00;
        bus_f.i_req_valid = 1'b0;
        bus_f.i_reg_addr  = 8'h00;
        bus_f.i_reg_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'd0, bus_a.o_CS_n}, 32'd1);
        chk("rst_wr_n", {31'd0, bus_a.o_WR_n}, 32'd1);
        chk("rst_a0",   {31'd0, bus_a.o_A0},   32'd0);
        chk("rst_d",    {24'd0, bus_a.o_D},    32'h00);
        chk("rst_busy", {31'd0, bus_a.o_busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {31'd0, bus_a.o_req_ready}, 32'd1);

`ifdef OPLL_BUS_WRITER_FIFO_EN
        // Five consecutive pushes: first pops at edge 1, ADDR_SETUP in cycle 2
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus_a.i_req_valid = 1'b1;
            bus_a.i_reg_addr  = 8'h20 + 8'(k);
            bus_a.i_reg_data  = 8'h01 + 8'(k);
            chk($sformatf("fifo_ready_%0d", k), {31'd0, bus_a.o_req_ready}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
        chk("fifo_full_ready", {31'd0, bus_a.o_req_ready}, 32'd0);
        for (int cyc = 5; cyc <= 512; cyc++) begin
            for (int j = 0; j < 5; j++) begin
                if (cyc == 2 + 102 * j) begin
                    chk($sformatf("fifo_addr_%0d", j), {24'd0, bus_a.o_D}, 32'h20 + j);
                    chk($sformatf("fifo_a0lo_%0d", j), {31'd0, bus_a.o_A0}, 32'd0);
                end
                if (cyc == 2 + 102 * j + 15) begin
                    chk($sformatf("fifo_data_%0d", j), {24'd0, bus_a.o_D}, 32'h01 + j);
                    chk($sformatf("fifo_a0hi_%0d", j), {31'd0, bus_a.o_A0}, 32'd1);
                end
            end
            if (cyc == 511) chk("fifo_busy_last", {31'd0, bus_a.o_busy}, 32'd1);
            if (cyc == 512) chk("fifo_busy_done", {31'd0, bus_a.o_busy}, 32'd0);
            if (cyc < 512) @(negedge clk);
        end
`else
        // Single write 0x10/0x5A with default timing
        send_a(8'h10, 8'h5A);
        for (int c = 1; c <= 104; c++) begin
            d_h[c]    = bus_a.o_D;
            a0_h[c]   = bus_a.o_A0;
            wr_h[c]   = bus_a.o_WR_n;
            cs_h[c]   = bus_a.o_CS_n;
            busy_h[c] = bus_a.o_busy;
            if (c < 104) @(negedge clk);
        end
        chk("s_c1_d",   {24'd0, d_h[1]},  32'h10);
        chk("s_c1_a0",  {31'd0, a0_h[1]}, 32'd0);
        chk("s_c1_wr",  {31'd0, wr_h[1]}, 32'd1);
        chk("s_c2_wr",  {31'd0, wr_h[2]}, 32'd0);
        chk("s_c3_cs",  {31'd0, cs_h[3]}, 32'd0);
        chk("s_c4_wr",  {31'd0, wr_h[4]}, 32'd1);
        chk("s_c15_a0", {31'd0, a0_h[15]}, 32'd0);
        chk("s_c16_d",  {24'd0, d_h[16]}, 32'h5A);
        chk("s_c16_a0", {31'd0, a0_h[16]}, 32'd1);
        chk("s_c16_wr", {31'd0, wr_h[16]}, 32'd1);
        chk("s_c17_wr", {31'd0, wr_h[17]}, 32'd0);
        chk("s_c18_cs", {31'd0, cs_h[18]}, 32'd0);
        chk("s_c19_wr", {31'd0, wr_h[19]}, 32'd1);
        chk("s_c102_busy", {31'd0, busy_h[102]}, 32'd1);
        chk("s_c103_busy", {31'd0, busy_h[103]}, 32'd0);
        chk("s_c103_d",    {24'd0, d_h[103]},    32'h5A);
        lows = 0;
        diffs = 0;
        for (int c = 1; c <= 104; c++) begin
            if (!wr_h[c]) lows++;
            if (wr_h[c] != cs_h[c]) diffs++;
        end
        chk("s_wr_low_cycles", lows, 32'd4);
        chk("s_cs_eq_wr", diffs, 32'd0);

        // Back-to-back: 0x30/0x31 then 0x40/0x41 held valid
        @(negedge clk);
        bus_a.i_req_valid = 1'b1;
        bus_a.i_reg_addr  = 8'h30;
        bus_a.i_reg_data  = 8'h31;
        @(posedge clk);
        @(negedge clk);
        bus_a.i_reg_addr  = 8'h40;
        bus_a.i_reg_data  = 8'h41;
        chk("b_c1_d", {24'd0, bus_a.o_D}, 32'h30);
        lowcnt = 0;
        while (!bus_a.o_req_ready && lowcnt < 300) begin
            lowcnt++;
            @(negedge clk);
        end
        chk("b_ready_low", lowcnt, 32'd101);
        chk("b_c102_d",  {24'd0, bus_a.o_D},  32'h31);
        chk("b_c102_a0", {31'd0, bus_a.o_A0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
        chk("b_c103_d",    {24'd0, bus_a.o_D},    32'h40);
        chk("b_c103_a0",   {31'd0, bus_a.o_A0},   32'd0);
        chk("b_c103_cs",   {31'd0, bus_a.o_CS_n}, 32'd1);
        chk("b_c103_busy", {31'd0, bus_a.o_busy}, 32'd1);
        @(negedge clk);
        chk("b_c104_wr", {31'd0, bus_a.o_WR_n}, 32'd0);
        repeat (110) @(negedge clk);
        chk("b_done_busy", {31'd0, bus_a.o_busy}, 32'd0);
        chk("b_done_d",    {24'd0, bus_a.o_D},    32'h41);

        // Minimal timing instance: 6-cycle write
        @(negedge clk);
        bus_f.i_req_valid = 1'b1;
        bus_f.i_reg_addr  = 8'hA5;
        bus_f.i_reg_data  = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        bus_f.i_req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            d_h[c]    = bus_f.o_D;
            a0_h[c]   = bus_f.o_A0;
            wr_h[c]   = bus_f.o_WR_n;
            busy_h[c] = bus_f.o_busy;
            if (c < 7) @(negedge clk);
        end
        chk("f_c1_d",    {24'd0, d_h[1]},  32'hA5);
        chk("f_c1_wr",   {31'd0, wr_h[1]}, 32'd1);
        chk("f_c2_wr",   {31'd0, wr_h[2]}, 32'd0);
        chk("f_c2_a0",   {31'd0, a0_h[2]}, 32'd0);
        chk("f_c3_wr",   {31'd0, wr_h[3]}, 32'd1);
        chk("f_c4_d",    {24'd0, d_h[4]},  32'h3C);
        chk("f_c4_wr",   {31'd0, wr_h[4]}, 32'd1);
        chk("f_c5_wr",   {31'd0, wr_h[5]}, 32'd0);
        chk("f_c5_a0",   {31'd0, a0_h[5]}, 32'd1);
        chk("f_c6_busy", {31'd0, busy_h[6]}, 32'd1);
        chk("f_c7_busy", {31'd0, busy_h[7]}, 32'd0);

        // Reset pulsed in the middle of DATA_STROBE
        send_a(8'h55, 8'hAA);
        repeat (16) @(negedge clk);
        chk("r_c17_wr", {31'd0, bus_a.o_WR_n}, 32'd0);
        chk("r_c17_a0", {31'd0, bus_a.o_A0},   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_cs",   {31'd0, bus_a.o_CS_n}, 32'd1);
        chk("r_async_wr",   {31'd0, bus_a.o_WR_n}, 32'd1);
        chk("r_async_d",    {24'd0, bus_a.o_D},    32'h00);
        chk("r_async_busy", {31'd0, bus_a.o_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        diffs = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (!bus_a.o_WR_n) lows++;
            if (bus_a.o_busy) diffs++;
        end
        chk("r_no_strobe", lows, 32'd0);
        chk("r_no_busy", diffs, 32'd0);
        chk("r_ready", {31'd0, bus_a.o_req_ready}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
